dmem_req_ctrl: RTL and testbench
================================

# dmem_req_ctrl

Data-side memory request controller between the CPU MEM stage and the SRAM-like data bus feeding the data cache. Each MEM-stage load or store becomes exactly one bus transaction:
- byte-lane-aligned write data, byte strobes and transfer size are generated for stores;
- read data is lane-selected and sign- or zero-extended for loads;
- the pipeline is held stalled until the transaction completes;
- an exception flush is honoured without corrupting bus protocol.

## Interface
Parameters:
- none (widths fixed at 32-bit MIPS)

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- mem_en  in  1  MEM stage holds a valid load/store
- mem_op  in  6  opcode field, one of `OP_LB/LBU/LH/LHU/LW/SB/SH/SW`
- mem_addr  in  32  effective byte address
- mem_wdata  in  32  unaligned store source register value
- flush  in  1  exception/flush from CP0; cancels current access
- mem_stall  out  1  hold pipeline
- mem_rdata  out  32  extended load result, valid while state is DONE
- adel  out  1  load address error (macro-dependent)
- ades  out  1  store address error (macro-dependent)
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  byte address; bits [1:0] are passed through
- data_wstrb  out  4  byte strobes; 0 on reads
- data_wdata  out  32  lane-aligned write data
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  read data returned or write done this cycle
- data_rdata  in  32  raw read word

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE → REQ when mem_en && !flush && !addr_err. The request is latched into registers: op, addr, aligned wdata, wstrb, size.
- REQ:
  - data_req=1; all request outputs are held stable from the latched registers.
  - On addr_ok && data_ok → DONE.
  - On addr_ok only → WAIT.
  - On flush with !addr_ok → IDLE, request dropped.
- WAIT:
  - On data_ok → DONE, or → IDLE if flush has been seen since acceptance.
  - On flush without data_ok → DRAIN.
- DRAIN: waits for data_ok, discards the result, → IDLE. No new request is issued meanwhile.
- DONE: mem_stall=0, mem_rdata valid; → IDLE next cycle unconditionally.
- mem_stall = mem_en && !flush && state≠DONE && !addr_err; also =1 in DRAIN regardless of mem_en.
- Store alignment by addr[1:0]:
  - SB: data placed in byte lane addr[1:0]; wstrb one-hot (0001,0010,0100,1000).
  - SH: addr=00 → lanes[15:0], wstrb 0011; addr=10 → lanes[31:16], wstrb 1100.
  - SW: wdata unchanged, wstrb 1111.
- Load extension:
  - LB/LBU: byte lane addr[1:0], sign/zero-extended.
  - LH/LHU: half at addr[1].
  - LW: whole word.
  - mem_rdata is registered on data_ok.
- Reset: state IDLE; data_req, data_wr, data_wstrb, adel, ades, mem_rdata, and all latched registers = 0; data_size=0.

## Timing
- Minimum load/store latency is 3 cycles from mem_en in IDLE:
  - cycle 0 IDLE;
  - cycle 1 REQ with addr_ok=data_ok=1;
  - cycle 2 DONE, stall low.
- data_req is asserted only in REQ. Once asserted it stays high with stable addr, data and strobes until addr_ok.
- At most one outstanding transaction; data_ok is only accepted in REQ (coincident with addr_ok), WAIT or DRAIN.
- flush during DONE has no effect; the result is already committed to the pipeline.
- Reset asserted mid-transaction returns to IDLE immediately. The bus side is reset by the same rst.

## Configuration
- ADDR_ALIGN_CHECK_EN defined:
  - addr_err = (LH/LHU/SH && addr[0]) || (LW/SW && addr[1:0]≠0).
  - On error in IDLE, adel (loads) or ades (stores) is asserted combinationally that cycle.
  - No bus request is issued, and mem_stall=0.
- ADDR_ALIGN_CHECK_EN undefined:
  - addr_err=0; adel/ades tied 0.
  - Misaligned SH passes mem_wdata unaligned with wstrb 1111.
  - Misaligned LW/LH returns the raw aligned word/half at addr with low bits ignored.

## Structure
- Shared header defines.vh (already holding `OP_*`) gains `DSIZE_BYTE/HALF/WORD` and the controller state encodings.
- One natural sub-module: load_extend (combinational lane select + sign/zero extension from op, addr[1:0], raw word).

## Test plan
- SW 0x1234_5678 to 0x100, addr_ok and data_ok in same cycle → data_wstrb=1111, data_size=2, stall for 2 cycles, DONE in cycle 2.
- SB 0x0000_00AB to 0x103 → wdata=0xAB00_0000, wstrb=1000; SH 0xBEEF to 0x102 → wdata=0xBEEF_0000, wstrb=1100.
- LB from 0x101, rdata=0x0000_8000 → mem_rdata=0xFFFF_FF80; LBU from the same address → 0x0000_0080; LHU from 0x102, rdata=0xF00D_0000 → 0x0000_F00D.
- addr_ok delayed 3 cycles → data_req, data_addr and data_wdata stable throughout; data_ok 2 cycles later → DONE, correct mem_rdata.
- flush in WAIT → DRAIN, mem_stall=1 until data_ok, no DONE, no new request; flush in REQ before addr_ok → IDLE, data_req drops next cycle.
- With ADDR_ALIGN_CHECK_EN: LW from 0x102 → adel=1, data_req never asserted, mem_stall=0; SH to 0x101 → ades=1.

Source files
------------

// File: rtl/dmem_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_req_ctrl_pkg
// Description : Shared opcodes, transfer sizes, controller states and
//               store-lane helpers for the data memory request controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_req_ctrl_pkg;

  // MIPS load/store opcode field values
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // Bus transfer size encodings
  localparam logic [1:0] DSIZE_BYTE = 2'd0;
  localparam logic [1:0] DSIZE_HALF = 2'd1;
  localparam logic [1:0] DSIZE_WORD = 2'd2;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // Lane-aligned store request fields
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } store_lane_t;

  // Bit 3 of the opcode separates stores (1) from loads (0)
  function automatic logic is_store_op(input logic [5:0] op);
    return op[3];
  endfunction

  // Low two opcode bits encode width: 00 byte, 01 half, 11 word
  function automatic logic [1:0] op_size(input logic [5:0] op);
    logic [1:0] s;
    case (op[1:0])
      2'b11:   s = DSIZE_WORD;
      2'b01:   s = DSIZE_HALF;
      default: s = DSIZE_BYTE;
    endcase
    return s;
  endfunction

  // Natural-alignment violation for the access width
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    logic [1:0] s;
    s = op_size(op);
    return ((s == DSIZE_HALF) && a[0]) || ((s == DSIZE_WORD) && (a != 2'b00));
  endfunction

  // Moves store data into its byte lanes; loads produce zero data/strobes.
  // A half store with addr[0] set (only reachable when alignment checking
  // is off) is passed through unshifted with all strobes on.
  function automatic store_lane_t align_store(input logic [5:0]  op,
                                              input logic [1:0]  a,
                                              input logic [31:0] d);
    store_lane_t r;
    r.size  = op_size(op);
    r.wdata = 32'd0;
    r.wstrb = 4'b0000;
    if (is_store_op(op)) begin
      case (r.size)
        DSIZE_BYTE: begin
          r.wdata = {24'd0, d[7:0]} << {a, 3'b000};
          r.wstrb = 4'b0001 << a;
        end
        DSIZE_HALF: begin
          if (a[0]) begin
            r.wdata = d;
            r.wstrb = 4'b1111;
          end else if (a[1]) begin
            r.wdata = {d[15:0], 16'd0};
            r.wstrb = 4'b1100;
          end else begin
            r.wdata = {16'd0, d[15:0]};
            r.wstrb = 4'b0011;
          end
        end
        default: begin
          r.wdata = d;
          r.wstrb = 4'b1111;
        end
      endcase
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_req_ctrl_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : dmem_req_ctrl_load_extend
// Description : Selects the addressed byte/half of a raw read word and
//               sign- or zero-extends it according to the load opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_req_ctrl_load_extend (
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw,
  output logic [31:0] result
);
  import dmem_req_ctrl_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by width/sign extension
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (op)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'd0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'd0, half_sel};
      default: result = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_req_ctrl
// Description : MEM-stage data request controller. Turns each load/store
//               into one bus transaction, stalls the pipeline until it
//               completes and drains an in-flight access on flush.
//               Optional macro ADDR_ALIGN_CHECK_EN enables address-error
//               detection (adel/ades) for misaligned half/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_req_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [5:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        adel,
  output logic        ades,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  import dmem_req_ctrl_pkg::*;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;

  logic        addr_err;
  store_lane_t lane;
  logic [31:0] ext_word;

`ifdef ADDR_ALIGN_CHECK_EN
  // Misalignment is only reported while a new access is being offered
  assign addr_err = misaligned(mem_op, mem_addr[1:0]);
  assign adel     = (state_q == ST_IDLE) && mem_en && addr_err && !is_store_op(mem_op);
  assign ades     = (state_q == ST_IDLE) && mem_en && addr_err &&  is_store_op(mem_op);
`else
  assign addr_err = 1'b0;
  assign adel     = 1'b0;
  assign ades     = 1'b0;
`endif

  assign lane = align_store(mem_op, mem_addr[1:0], mem_wdata);

  dmem_req_ctrl_load_extend u_load_extend (
    .op      (op_q),
    .addr_lo (addr_q[1:0]),
    .raw     (data_rdata),
    .result  (ext_word)
  );

  // Next-state, request latch and load-result capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    size_d  = size_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_en && !flush && !addr_err) begin
          state_d = ST_REQ;
          op_d    = mem_op;
          addr_d  = mem_addr;
          wdata_d = lane.wdata;
          wstrb_d = lane.wstrb;
          size_d  = lane.size;
          wr_d    = is_store_op(mem_op);
        end
      end
      ST_REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            // A flush in the completing cycle discards the result
            state_d = flush ? ST_IDLE : ST_DONE;
            if (!flush && !wr_q) rdata_d = ext_word;
          end else begin
            state_d = flush ? ST_DRAIN : ST_WAIT;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          state_d = flush ? ST_IDLE : ST_DONE;
          if (!flush && !wr_q) rdata_d = ext_word;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (data_data_ok) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_REQ);
  end

  // State and latched request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 6'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = wstrb_q;
  assign data_wdata = wdata_q;
  assign mem_rdata  = rdata_q;
  assign mem_stall  = (mem_en && !flush && (state_q != ST_DONE) && !addr_err)
                    || (state_q == ST_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_dmem_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_req_ctrl
// Description : Directed self-checking bench for dmem_req_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_req_ctrl;
  import dmem_req_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0;
  logic [5:0]  mem_op = 6'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        flush = 1'b0;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        adel, ades;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  dmem_req_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .flush        (flush),
    .mem_stall    (mem_stall),
    .mem_rdata    (mem_rdata),
    .adel         (adel),
    .ades         (ades),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One zero-wait transaction: IDLE -> REQ (addr_ok+data_ok) -> DONE
  task automatic xfer(input  logic [5:0]  op,
                      input  logic [31:0] addr,
                      input  logic [31:0] wd,
                      input  logic [31:0] rd,
                      output logic [31:0] o_wdata,
                      output logic [3:0]  o_wstrb,
                      output logic [1:0]  o_size,
                      output logic        o_req,
                      output logic        o_wr,
                      output logic [31:0] o_rdata,
                      output logic        o_stall);
    mem_en = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wd;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    tick();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rd;
    #2;
    o_wdata = data_wdata; o_wstrb = data_wstrb; o_size = data_size;
    o_req = data_req; o_wr = data_wr;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #2;
    o_rdata = mem_rdata; o_stall = mem_stall;
    tick();
    mem_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd, rdv;
    logic [3:0]  ws;
    logic [1:0]  sz;
    logic        rq, wr, st;

    // Reset state
    tick(); tick();
    chk1("rst_req",   data_req, 1'b0);
    chk1("rst_wr",    data_wr, 1'b0);
    chk ("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
    chk ("rst_size",  {30'd0, data_size}, 32'd0);
    chk ("rst_rdata", mem_rdata, 32'd0);
    chk1("rst_adel",  adel, 1'b0);
    chk1("rst_ades",  ades, 1'b0);
    rst = 1'b0;
    tick();
    chk1("idle_stall", mem_stall, 1'b0);

    // SW with minimum latency, checked cycle by cycle
    mem_en = 1'b1; mem_op = OP_SW; mem_addr = 32'h100; mem_wdata = 32'h1234_5678;
    #2;
    chk1("sw_c0_stall", mem_stall, 1'b1);
    chk1("sw_c0_req",   data_req, 1'b0);
    tick();
    data_addr_ok = 1'b1; data_data_ok = 1'b1;
    #2;
    chk1("sw_c1_req",   data_req, 1'b1);
    chk1("sw_c1_stall", mem_stall, 1'b1);
    chk1("sw_c1_wr",    data_wr, 1'b1);
    chk ("sw_c1_addr",  data_addr, 32'h100);
    chk ("sw_c1_wdata", data_wdata, 32'h1234_5678);
    chk ("sw_c1_wstrb", {28'd0, data_wstrb}, 32'hF);
    chk ("sw_c1_size",  {30'd0, data_size}, 32'd2);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #2;
    chk1("sw_c2_stall", mem_stall, 1'b0);
    chk1("sw_c2_req",   data_req, 1'b0);
    tick();
    mem_en = 1'b0;

    // Store lane alignment
    xfer(OP_SB, 32'h103, 32'h0000_00AB, 32'h0, wd, ws, sz, rq, wr, rdv, st);
    chk ("sb3_wdata", wd, 32'hAB00_0000);
    chk ("sb3_wstrb", {28'd0, ws}, 32'h8);
    chk ("sb3_size",  {30'd0, sz}, 32'd0);
    chk1("sb3_req",   rq, 1'b1);
    xfer(OP_SB, 32'h101, 32'hFFFF_FF5A, 32'h0, wd, ws, sz, rq, wr, rdv, st);
    chk ("sb1_wdata", wd, 32'h0000_5A00);
    chk ("sb1_wstrb", {28'd0, ws}, 32'h2);
    xfer(OP_SH, 32'h102, 32'h0000_BEEF, 32'h0, wd, ws, sz, rq, wr, rdv, st);
    chk ("sh2_wdata", wd, 32'hBEEF_0000);
    chk ("sh2_wstrb", {28'd0, ws}, 32'hC);
    chk ("sh2_size",  {30'd0, sz}, 32'd1);
    xfer(OP_SH, 32'h100, 32'h1234_BEEF, 32'h0, wd, ws, sz, rq, wr, rdv, st);
    chk ("sh0_wdata", wd, 32'h0000_BEEF);
    chk ("sh0_wstrb", {28'd0, ws}, 32'h3);

    // Load extension
    xfer(OP_LB, 32'h101, 32'h0, 32'h0000_8000, wd, ws, sz, rq, wr, rdv, st);
    chk ("lb_rdata",  rdv, 32'hFFFF_FF80);
    chk ("lb_wstrb",  {28'd0, ws}, 32'h0);
    chk1("lb_wr",     wr, 1'b0);
    chk1("lb_stall",  st, 1'b0);
    xfer(OP_LBU, 32'h101, 32'h0, 32'h0000_8000, wd, ws, sz, rq, wr, rdv, st);
    chk ("lbu_rdata", rdv, 32'h0000_0080);
    xfer(OP_LHU, 32'h102, 32'h0, 32'hF00D_0000, wd, ws, sz, rq, wr, rdv, st);
    chk ("lhu_rdata", rdv, 32'h0000_F00D);
    chk ("lhu_size",  {30'd0, sz}, 32'd1);
    xfer(OP_LH, 32'h100, 32'h0, 32'h1234_8001, wd, ws, sz, rq, wr, rdv, st);
    chk ("lh_rdata",  rdv, 32'hFFFF_8001);
    xfer(OP_LW, 32'h104, 32'h0, 32'hDEAD_BEEF, wd, ws, sz, rq, wr, rdv, st);
    chk ("lw_rdata",  rdv, 32'hDEAD_BEEF);

    // Delayed addr_ok then delayed data_ok
    mem_en = 1'b1; mem_op = OP_LW; mem_addr = 32'h108; mem_wdata = 32'h0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #2;
      chk1("dly_req",   data_req, 1'b1);
      chk ("dly_addr",  data_addr, 32'h108);
      chk1("dly_stall", mem_stall, 1'b1);
      tick();
    end
    data_addr_ok = 1'b1;
    #2;
    chk1("dly_acc_req", data_req, 1'b1);
    tick();
    data_addr_ok = 1'b0;
    #2;
    chk1("dly_wait_req",   data_req, 1'b0);
    chk1("dly_wait_stall", mem_stall, 1'b1);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    #2;
    chk ("dly_rdata", mem_rdata, 32'hCAFE_F00D);
    chk1("dly_stall_done", mem_stall, 1'b0);
    tick();
    mem_en = 1'b0;

    // Flush in WAIT drains the outstanding access
    mem_en = 1'b1; mem_op = OP_LW; mem_addr = 32'h200;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; mem_en = 1'b0;
    #2;
    chk1("drain_stall1", mem_stall, 1'b1);
    chk1("drain_req1",   data_req, 1'b0);
    tick();
    #2;
    chk1("drain_stall2", mem_stall, 1'b1);
    chk1("drain_req2",   data_req, 1'b0);
    data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
    tick();
    data_data_ok = 1'b0;
    #2;
    chk1("drain_end_stall", mem_stall, 1'b0);
    chk1("drain_end_req",   data_req, 1'b0);
    chk ("drain_rdata",     mem_rdata, 32'hCAFE_F00D);

    // Flush in REQ before addr_ok drops the request
    mem_en = 1'b1; mem_op = OP_LW; mem_addr = 32'h204;
    tick();
    #2;
    chk1("freq_req", data_req, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0; mem_en = 1'b0;
    #2;
    chk1("freq_drop_req",   data_req, 1'b0);
    chk1("freq_drop_stall", mem_stall, 1'b0);
    tick();
    #2;
    chk1("freq_idle_req", data_req, 1'b0);

    // Asynchronous reset mid-transaction
    mem_en = 1'b1; mem_op = OP_SW; mem_addr = 32'h300; mem_wdata = 32'h5555_AAAA;
    tick();
    rst = 1'b1;
    #1;
    chk1("arst_req",   data_req, 1'b0);
    chk1("arst_wr",    data_wr, 1'b0);
    chk ("arst_wdata", data_wdata, 32'h0);
    mem_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

`ifdef ADDR_ALIGN_CHECK_EN
    mem_en = 1'b1; mem_op = OP_LW; mem_addr = 32'h102;
    #2;
    chk1("adel_lw",       adel, 1'b1);
    chk1("adel_lw_ades",  ades, 1'b0);
    chk1("adel_lw_stall", mem_stall, 1'b0);
    tick();
    #2;
    chk1("adel_lw_req", data_req, 1'b0);
    mem_op = OP_SH; mem_addr = 32'h101;
    #2;
    chk1("ades_sh",       ades, 1'b1);
    chk1("ades_sh_adel",  adel, 1'b0);
    chk1("ades_sh_stall", mem_stall, 1'b0);
    tick();
    #2;
    chk1("ades_sh_req", data_req, 1'b0);
    mem_en = 1'b0;
    tick();
`else
    mem_en = 1'b1; mem_op = OP_LW; mem_addr = 32'h102;
    #2;
    chk1("noalign_adel", adel, 1'b0);
    mem_en = 1'b0;
    xfer(OP_SH, 32'h101, 32'h0000_BEEF, 32'h0, wd, ws, sz, rq, wr, rdv, st);
    chk ("mis_sh_wdata", wd, 32'h0000_BEEF);
    chk ("mis_sh_wstrb", {28'd0, ws}, 32'hF);
    xfer(OP_LW, 32'h102, 32'h0, 32'h8765_4321, wd, ws, sz, rq, wr, rdv, st);
    chk ("mis_lw_rdata", rdv, 32'h8765_4321);
    xfer(OP_LH, 32'h103, 32'h0, 32'h8765_4321, wd, ws, sz, rq, wr, rdv, st);
    chk ("mis_lh_rdata", rdv, 32'hFFFF_8765);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
